// File: rtl/time_set_ctrl.sv
// Digital-clock mode/set controller: debounces MODE/UP/DOWN, edits a BCD preset
// and commits it to the timer with a one-cycle load strobe.
//
// state | meaning
// RUN   | timer counting, keys UP/DOWN ignored
// SET_H | editing hours preset
// SET_M | editing minutes preset
// SET_S | editing seconds preset, MODE commits with PE
module time_set_ctrl #(
  parameter int DEBOUNCE_CYC = 200,
  parameter int REPEAT_DLY   = 5000,
  parameter int REPEAT_PER   = 2000,
  parameter int TIMEOUT      = 300000
) (
  input  logic       CP,
  input  logic       CR,
  input  logic       KEY_MODE,
  input  logic       KEY_UP,
  input  logic       KEY_DOWN,
  input  logic [7:0] Q_H,
  input  logic [7:0] Q_M,
  input  logic [7:0] Q_S,
  output logic [7:0] D_H,
  output logic [7:0] D_M,
  output logic [7:0] D_S,
  output logic       PE,
  output logic       CE,
  output logic [1:0] MODE,
  output logic [2:0] SEL
);

  localparam int CW   = $clog2(DEBOUNCE_CYC + 1);
  localparam int RMAX = (REPEAT_DLY > REPEAT_PER) ? REPEAT_DLY : REPEAT_PER;
  localparam int RW   = $clog2(RMAX + 1);
  localparam int IW   = $clog2(TIMEOUT + 1);

  localparam logic [CW-1:0] DB_TOP  = CW'(DEBOUNCE_CYC - 1);
  localparam logic [RW-1:0] DLY_TOP = RW'(REPEAT_DLY - 1);
  localparam logic [RW-1:0] PER_TOP = RW'(REPEAT_PER - 1);
  localparam logic [IW-1:0] TO_TOP  = IW'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    RUN   = 2'b00,
    SET_H = 2'b01,
    SET_M = 2'b10,
    SET_S = 2'b11
  } state_e;

  function automatic logic [7:0] bcd_inc(input logic [7:0] v, input logic [7:0] max);
    if (v == max) return 8'h00;
    if (v[3:0] == 4'd9) return {v[7:4] + 4'd1, 4'd0};
    return {v[7:4], v[3:0] + 4'd1};
  endfunction

  function automatic logic [7:0] bcd_dec(input logic [7:0] v, input logic [7:0] max);
    if (v == 8'h00) return max;
    if (v[3:0] == 4'd0) return {v[7:4] - 4'd1, 4'd9};
    return {v[7:4], v[3:0] - 4'd1};
  endfunction

  // Valid packed BCD orders the same as plain binary, so one compare covers range.
  function automatic logic [7:0] bcd_snap(input logic [7:0] v, input logic [7:0] max);
    if (v[7:4] > 4'd9 || v[3:0] > 4'd9 || v > max) return 8'h00;
    return v;
  endfunction

  // Key conditioning, bit order {DOWN, UP, MODE}.
  logic [2:0]    key_raw, sync1_q, sync2_q, lvl_q, press_q;
  logic [CW-1:0] db_cnt_q [3];

  assign key_raw = {KEY_DOWN, KEY_UP, KEY_MODE};

  always_ff @(posedge CP) begin
    if (!CR) begin
      sync1_q <= '0;
      sync2_q <= '0;
      lvl_q   <= '0;
      press_q <= '0;
      for (int i = 0; i < 3; i++) db_cnt_q[i] <= '0;
    end else begin
      sync1_q <= key_raw;
      sync2_q <= sync1_q;
      press_q <= '0;
      for (int i = 0; i < 3; i++) begin
        if (sync2_q[i] == lvl_q[i]) begin
          db_cnt_q[i] <= DB_TOP;
        end else if (db_cnt_q[i] == '0) begin
          lvl_q[i]    <= sync2_q[i];
          press_q[i]  <= sync2_q[i];
          db_cnt_q[i] <= DB_TOP;
        end else begin
          db_cnt_q[i] <= db_cnt_q[i] - CW'(1);
        end
      end
    end
  end

  logic mode_press, up_press, dn_press, up_lvl, dn_lvl;
  assign mode_press = press_q[0];
  assign up_press   = press_q[1];
  assign dn_press   = press_q[2];
  assign up_lvl     = lvl_q[1];
  assign dn_lvl     = lvl_q[2];

  state_e        state_q, state_d;
  logic [7:0]    d_h_q, d_h_d, d_m_q, d_m_d, d_s_q, d_s_d;
  logic          pe_q, pe_d, ce_q, ce_d;
  logic [2:0]    sel_q, sel_d;
  logic          rep_act_q, rep_act_d;
  logic [RW-1:0] rep_q, rep_d;
  logic [IW-1:0] idle_q, idle_d;

  logic in_set, one_held, rep_fire, up_step, dn_step, activity, timeout;

  assign in_set   = (state_q != RUN);
  assign one_held = up_lvl ^ dn_lvl;
  assign rep_fire = in_set & rep_act_q & one_held & (rep_q == '0);
  assign up_step  = in_set & up_lvl & ~dn_lvl & (up_press | rep_fire);
  assign dn_step  = in_set & dn_lvl & ~up_lvl & (dn_press | rep_fire);
  assign activity = mode_press | up_press | dn_press | rep_fire;
  assign timeout  = in_set & ~activity & (idle_q == '0);

  always_comb begin
    state_d   = state_q;
    d_h_d     = d_h_q;
    d_m_d     = d_m_q;
    d_s_d     = d_s_q;
    pe_d      = 1'b0;
    ce_d      = (state_q == RUN);
    rep_act_d = rep_act_q;
    rep_d     = rep_q;
    idle_d    = idle_q;
    sel_d     = 3'b000;

    if (!in_set || !one_held || mode_press || timeout) begin
      rep_act_d = 1'b0;
      rep_d     = '0;
    end else if (up_press || dn_press) begin
      rep_act_d = 1'b1;
      rep_d     = DLY_TOP;
    end else if (rep_fire) begin
      rep_d = PER_TOP;
    end else if (rep_act_q) begin
      rep_d = rep_q - RW'(1);
    end

    if (!in_set || activity) idle_d = TO_TOP;
    else if (idle_q != '0)   idle_d = idle_q - IW'(1);

    // MODE wins over a same-cycle edit step, so steps sit in the else branches.
    case (state_q)
      RUN: begin
        if (mode_press) begin
          state_d = SET_H;
          d_h_d   = bcd_snap(Q_H, 8'h23);
          d_m_d   = bcd_snap(Q_M, 8'h59);
          d_s_d   = bcd_snap(Q_S, 8'h59);
        end
      end
      SET_H: begin
        if (mode_press)   state_d = SET_M;
        else if (timeout) state_d = RUN;
        else if (up_step) d_h_d = bcd_inc(d_h_q, 8'h23);
        else if (dn_step) d_h_d = bcd_dec(d_h_q, 8'h23);
      end
      SET_M: begin
        if (mode_press)   state_d = SET_S;
        else if (timeout) state_d = RUN;
        else if (up_step) d_m_d = bcd_inc(d_m_q, 8'h59);
        else if (dn_step) d_m_d = bcd_dec(d_m_q, 8'h59);
      end
      SET_S: begin
        if (mode_press) begin
          state_d = RUN;
          pe_d    = 1'b1;
        end
        else if (timeout) state_d = RUN;
        else if (up_step) d_s_d = bcd_inc(d_s_q, 8'h59);
        else if (dn_step) d_s_d = bcd_dec(d_s_q, 8'h59);
      end
      default: state_d = RUN;
    endcase

    case (state_d)
      SET_H:   sel_d = 3'b100;
      SET_M:   sel_d = 3'b010;
      SET_S:   sel_d = 3'b001;
      default: sel_d = 3'b000;
    endcase
  end

  always_ff @(posedge CP) begin
    if (!CR) begin
      state_q   <= RUN;
      d_h_q     <= 8'h00;
      d_m_q     <= 8'h00;
      d_s_q     <= 8'h00;
      pe_q      <= 1'b0;
      ce_q      <= 1'b1;
      sel_q     <= 3'b000;
      rep_act_q <= 1'b0;
      rep_q     <= '0;
      idle_q    <= '0;
    end else begin
      state_q   <= state_d;
      d_h_q     <= d_h_d;
      d_m_q     <= d_m_d;
      d_s_q     <= d_s_d;
      pe_q      <= pe_d;
      ce_q      <= ce_d;
      sel_q     <= sel_d;
      rep_act_q <= rep_act_d;
      rep_q     <= rep_d;
      idle_q    <= idle_d;
    end
  end

  assign D_H  = d_h_q;
  assign D_M  = d_m_q;
  assign D_S  = d_s_q;
  assign PE   = pe_q;
  assign CE   = ce_q;
  assign MODE = state_q;
  assign SEL  = sel_q;

endmodule

// File: tb/tb_time_set_ctrl.sv
// Bench for time_set_ctrl: directed and randomized key sequences checked against
// an integer-arithmetic model of the clock preset editor.
module tb_time_set_ctrl;

  localparam int DEB = 4;
  localparam int RDLY = 20;
  localparam int RPER = 5;
  localparam int TOUT = 200;

  logic       cp = 1'b0, cr = 1'b0;
  logic       k_mode = 1'b0, k_up = 1'b0, k_dn = 1'b0;
  logic [7:0] q_h = 8'h00, q_m = 8'h00, q_s = 8'h00;
  logic [7:0] d_h, d_m, d_s;
  logic       pe, ce;
  logic [1:0] mode;
  logic [2:0] sel;

  int tests = 0;
  int fails = 0;

  int m_mode = 0;
  int fld [3];
  int exp_pe = 0;
  int pe_cnt = 0;
  logic [7:0] pe_dh, pe_dm, pe_ds;
  logic       pe_ce;

  time_set_ctrl #(
    .DEBOUNCE_CYC(DEB), .REPEAT_DLY(RDLY), .REPEAT_PER(RPER), .TIMEOUT(TOUT)
  ) dut (
    .CP(cp), .CR(cr), .KEY_MODE(k_mode), .KEY_UP(k_up), .KEY_DOWN(k_dn),
    .Q_H(q_h), .Q_M(q_m), .Q_S(q_s),
    .D_H(d_h), .D_M(d_m), .D_S(d_s),
    .PE(pe), .CE(ce), .MODE(mode), .SEL(sel)
  );

  always #5 cp = ~cp;

  always @(negedge cp) begin
    if (pe) begin
      pe_cnt = pe_cnt + 1;
      pe_dh  = d_h;
      pe_dm  = d_m;
      pe_ds  = d_s;
      pe_ce  = ce;
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests = tests + 1;
    assert (obs === exp) else begin
      fails = fails + 1;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int fmax(input int f);
    return (f == 0) ? 23 : 59;
  endfunction

  function automatic int wrap(input int v, input int mx, input int dir);
    if (dir > 0) return (v == mx) ? 0 : v + 1;
    return (v == 0) ? mx : v - 1;
  endfunction

  function automatic logic [7:0] to_bcd(input int v);
    return 8'(((v / 10) * 16) + (v % 10));
  endfunction

  function automatic int snap(input logic [7:0] v, input int mx);
    int hi, lo;
    hi = int'(v[7:4]);
    lo = int'(v[3:0]);
    if (hi > 9 || lo > 9) return 0;
    if (hi * 10 + lo > mx) return 0;
    return hi * 10 + lo;
  endfunction

  // Steps for a held key: the press itself plus every repeat instant that
  // still falls inside the debounced-high window of hold cycles.
  function automatic int rep_steps(input int hold);
    int n;
    n = 1;
    for (int t = RDLY; t <= hold - 1; t += RPER) n++;
    return n;
  endfunction

  task automatic tick(input int n);
    repeat (n) @(negedge cp);
  endtask

  // k: 0 MODE, 1 UP, 2 DOWN, 3 UP+DOWN, 4 MODE+UP
  task automatic press_key(input int k, input int hold);
    k_mode = (k == 0) || (k == 4);
    k_up   = (k == 1) || (k == 3) || (k == 4);
    k_dn   = (k == 2) || (k == 3);
    tick(hold);
    k_mode = 1'b0;
    k_up   = 1'b0;
    k_dn   = 1'b0;
    tick(10);
  endtask

  task automatic do_mode();
    press_key(0, 8);
    if (m_mode == 0) begin
      fld[0] = snap(q_h, 23);
      fld[1] = snap(q_m, 59);
      fld[2] = snap(q_s, 59);
      m_mode = 1;
    end else if (m_mode == 3) begin
      exp_pe = exp_pe + 1;
      m_mode = 0;
    end else begin
      m_mode = m_mode + 1;
    end
  endtask

  task automatic do_step(input int dir, input int hold);
    int n;
    press_key((dir > 0) ? 1 : 2, hold);
    n = rep_steps(hold);
    if (m_mode != 0)
      for (int i = 0; i < n; i++) fld[m_mode-1] = wrap(fld[m_mode-1], fmax(m_mode-1), dir);
  endtask

  task automatic check_state(input string tag);
    int exp_sel;
    exp_sel = (m_mode == 1) ? 4 : (m_mode == 2) ? 2 : (m_mode == 3) ? 1 : 0;
    check({tag, "_mode"}, 32'(mode), 32'(m_mode));
    check({tag, "_sel"}, 32'(sel), 32'(exp_sel));
    check({tag, "_ce"}, 32'(ce), (m_mode == 0) ? 32'd1 : 32'd0);
    check({tag, "_dh"}, 32'(d_h), 32'(to_bcd(fld[0])));
    check({tag, "_dm"}, 32'(d_m), 32'(to_bcd(fld[1])));
    check({tag, "_ds"}, 32'(d_s), 32'(to_bcd(fld[2])));
  endtask

  task automatic check_commit(input string tag);
    check({tag, "_pecnt"}, 32'(pe_cnt), 32'(exp_pe));
    check({tag, "_pedh"}, 32'(pe_dh), 32'(to_bcd(fld[0])));
    check({tag, "_pedm"}, 32'(pe_dm), 32'(to_bcd(fld[1])));
    check({tag, "_peds"}, 32'(pe_ds), 32'(to_bcd(fld[2])));
    check({tag, "_pece"}, 32'(pe_ce), 32'd0);
  endtask

  initial begin
    int n, dir, hold;
    fld[0] = 0; fld[1] = 0; fld[2] = 0;

    // reset
    cr = 1'b0;
    tick(2);
    cr = 1'b1;
    tick(2);
    check_state("reset");
    check("reset_pe", 32'(pe), 32'd0);

    // short glitches never become press events
    press_key(1, 3);
    press_key(0, 3);
    check_state("glitch");
    check("glitch_pecnt", 32'(pe_cnt), 32'(exp_pe));

    // snapshot, edit hours, commit
    q_h = 8'h12; q_m = 8'h34; q_s = 8'h56;
    do_mode();
    check_state("snap");
    do_step(1, 8);
    do_step(1, 8);
    check_state("up2");
    do_mode(); do_mode(); do_mode();
    check_commit("commit");
    check_state("commit");

    // wraps at field boundaries
    q_h = 8'h23; q_m = 8'h00; q_s = 8'h59;
    do_mode();
    do_step(1, 8);
    check_state("wrap_h");
    do_mode();
    do_step(-1, 8);
    check_state("wrap_m");
    do_mode();
    do_step(1, 8);
    check_state("wrap_s");
    do_mode();
    check_commit("wrap_commit");

    // randomized presets and edits
    for (int it = 0; it < 6; it++) begin
      q_h = ($urandom_range(0, 1) == 1) ? to_bcd($urandom_range(0, 23)) : 8'($urandom);
      q_m = ($urandom_range(0, 1) == 1) ? to_bcd($urandom_range(0, 59)) : 8'($urandom);
      q_s = ($urandom_range(0, 1) == 1) ? to_bcd($urandom_range(0, 59)) : 8'($urandom);
      do_mode();
      check_state("rnd_snap");
      for (int f = 0; f < 3; f++) begin
        n = $urandom_range(0, 3);
        for (int j = 0; j < n; j++) begin
          dir = ($urandom_range(0, 1) == 1) ? 1 : -1;
          do_step(dir, 8);
        end
        check_state("rnd_edit");
        do_mode();
      end
      check_commit("rnd_commit");
    end

    // auto-repeat on minutes from 10
    q_h = 8'h00; q_m = 8'h10; q_s = 8'h00;
    do_mode();
    do_mode();
    do_step(1, 40);
    check("rep40_dm", 32'(d_m), 32'h15);
    check_state("rep40");
    for (int it = 0; it < 3; it++) begin
      hold = $urandom_range(10, 60);
      dir  = ($urandom_range(0, 1) == 1) ? 1 : -1;
      do_step(dir, hold);
      check_state("rep_rnd");
    end
    press_key(3, 40);
    check_state("both_held");
    do_mode(); do_mode();
    check_commit("rep_commit");

    // idle timeout keeps edited preset and issues no load
    do_mode();
    do_step(1, 8);
    tick(150);
    check_state("to_wait");
    tick(60);
    m_mode = 0;
    check_state("timeout");
    check("timeout_pecnt", 32'(pe_cnt), 32'(exp_pe));

    // MODE and UP pressed together: state advances, no step
    do_mode();
    press_key(4, 8);
    m_mode = 2;
    check_state("precedence");
    do_mode(); do_mode();
    check_commit("prec_commit");

    // invalid snapshot then reset mid-edit
    q_h = 8'h2A; q_m = 8'h61; q_s = 8'h45;
    do_mode();
    check_state("invalid_snap");
    do_mode();
    do_step(1, 8);
    check_state("pre_reset");
    cr = 1'b0;
    tick(2);
    cr = 1'b1;
    tick(2);
    m_mode = 0;
    fld[0] = 0; fld[1] = 0; fld[2] = 0;
    check_state("mid_reset");
    check("mid_reset_pecnt", 32'(pe_cnt), 32'(exp_pe));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
